// File: rtl/module_keypad_scan.sv
// -----------------------------------------------------------------------------
// module_keypad_scan
//
// Scanning controller for a 4x4 active-low matrix keypad. One column strobe is
// driven low at a time and held for SCAN_DIV cycles. The four row lines are
// synchronized and sampled once per dwell, on the "tick" cycle. A single pressed
// key must match on DEBOUNCE_CNT consecutive ticks before it is accepted. It
// must then be released for DEBOUNCE_CNT consecutive ticks before scanning
// resumes.
//
// Handshake: there is no ready input. key_valid_o is a one-cycle event pulse
// that the consumer must sample every cycle. key_code_o and dato_codf_o are
// stable from that pulse until the next accepted press.
//
// Ports:
//   clk_i        system clock
//   rst_n_i      synchronous active-low reset
//   fila_i[3:0]  raw row lines, active-low, asynchronous to clk_i
//   columna_o    one-hot-low column strobe (code 0 -> 1110 ... code 3 -> 0111)
//   dato_codc_o  live column code
//   dato_codf_o  row code of the last accepted key
//   key_code_o   {row, column} of the last accepted key
//   key_valid_o  one-cycle pulse per accepted press
//   key_held_o   high while the accepted key stays pressed
// -----------------------------------------------------------------------------
module module_keypad_scan #(
    parameter int SCAN_DIV     = 27000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] fila_i,
    output logic [3:0] columna_o,
    output logic [1:0] dato_codc_o,
    output logic [1:0] dato_codf_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       fila_m_q, fila_s_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       columna_q, columna_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] rel_q, rel_d;
    logic [1:0]       codf_q, codf_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;

    logic       tick;
    logic       row_valid;
    logic [1:0] row_enc;
    logic [3:0] row_pat;
    logic       row_released;
    logic       accept;
    logic [1:0] acc_row;

    assign tick = (div_q == DIV_LAST);

    // A row pattern is a key only when exactly one line is low.
    always_comb begin
        row_valid = 1'b1;
        row_enc   = 2'd0;
        case (fila_s_q)
            4'b1110: row_enc = 2'd0;
            4'b1101: row_enc = 2'd1;
            4'b1011: row_enc = 2'd2;
            4'b0111: row_enc = 2'd3;
            default: row_valid = 1'b0;
        endcase
    end

    always_comb begin
        row_pat = 4'b1110;
        case (row_q)
            2'd0: row_pat = 4'b1110;
            2'd1: row_pat = 4'b1101;
            2'd2: row_pat = 4'b1011;
            2'd3: row_pat = 4'b0111;
            default: row_pat = 4'b1110;
        endcase
    end

    // Release only looks at the latched row; other rows are ignored in HOLD.
    assign row_released = fila_s_q[row_q];

    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + DIV_ONE;
        col_d   = col_q;
        row_d   = row_q;
        match_d = match_q;
        rel_d   = rel_q;
        codf_d  = codf_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        accept  = 1'b0;
        acc_row = row_q;

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (row_valid) begin
                        row_d   = row_enc;
                        acc_row = row_enc;
                        // The detecting tick is itself the first match.
                        if (CNT_LAST == '0) begin
                            accept = 1'b1;
                        end else begin
                            match_d = CNT_ONE;
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (fila_s_q == row_pat) begin
                        if (match_q >= CNT_LAST) begin
                            accept = 1'b1;
                        end else begin
                            match_d = match_q + CNT_ONE;
                        end
                    end else begin
                        match_d = '0;
                        col_d   = col_q + 2'd1;
                        state_d = ST_SCAN;
                    end
                end
                ST_HOLD: begin
                    if (row_released) begin
                        if (rel_q >= CNT_LAST) begin
                            rel_d   = '0;
                            held_d  = 1'b0;
                            col_d   = col_q + 2'd1;
                            state_d = ST_SCAN;
                        end else begin
                            rel_d = rel_q + CNT_ONE;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end

        if (accept) begin
            valid_d = 1'b1;
            held_d  = 1'b1;
            codf_d  = acc_row;
            code_d  = {acc_row, col_q};
            match_d = '0;
            rel_d   = '0;
            state_d = ST_HOLD;
        end

        case (col_d)
            2'd0: columna_d = 4'b1110;
            2'd1: columna_d = 4'b1101;
            2'd2: columna_d = 4'b1011;
            2'd3: columna_d = 4'b0111;
            default: columna_d = 4'b1110;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_SCAN;
            fila_m_q  <= 4'b1111;
            fila_s_q  <= 4'b1111;
            div_q     <= '0;
            col_q     <= 2'd0;
            columna_q <= 4'b1110;
            row_q     <= 2'd0;
            match_q   <= '0;
            rel_q     <= '0;
            codf_q    <= 2'd0;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fila_m_q  <= fila_i;
            fila_s_q  <= fila_m_q;
            div_q     <= div_d;
            col_q     <= col_d;
            columna_q <= columna_d;
            row_q     <= row_d;
            match_q   <= match_d;
            rel_q     <= rel_d;
            codf_q    <= codf_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
        end
    end

    assign columna_o   = columna_q;
    assign dato_codc_o = col_q;
    assign dato_codf_o = codf_q;
    assign key_code_o  = code_q;
    assign key_valid_o = valid_q;
    assign key_held_o  = held_q;

endmodule

// File: tb/tb_module_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_module_keypad_scan
//
// Bench for module_keypad_scan with SCAN_DIV = 4 and DEBOUNCE_CNT = 3.
// A behavioural keypad model tracks the expected outputs every cycle. Directed
// scenarios add literal checks on top of it, and a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_module_keypad_scan;

    localparam int SD = 4;
    localparam int DC = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] fila = 4'b1111;
    logic [3:0] columna;
    logic [1:0] codc, codf;
    logic [3:0] key_code;
    logic       key_valid, key_held;

    int checks = 0;
    int failures = 0;
    int pulse_count = 0;

    module_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .fila_i     (fila),
        .columna_o  (columna),
        .dato_codc_o(codc),
        .dato_codf_o(codf),
        .key_code_o (key_code),
        .key_valid_o(key_valid),
        .key_held_o (key_held)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 scanning, 1 confirming a press, 2 key held
    int   m_div, m_col, m_mode, m_row, m_cnt, m_rel;
    logic [3:0] m_s1, m_s2;
    logic [1:0] e_codf;
    logic [3:0] e_code;
    logic e_valid, e_held;
    bit   m_ready = 0;

    // Index of the single low line, or -1 when zero or several are low.
    function automatic int low_index(input logic [3:0] p);
        int n = 0;
        int idx = -1;
        for (int i = 0; i < 4; i++) if (p[i] == 1'b0) begin n++; idx = i; end
        return (n == 1) ? idx : -1;
    endfunction

    function automatic logic [3:0] strobe(input int c);
        logic [3:0] v;
        v = 4'b1111;
        v[c] = 1'b0;
        return v;
    endfunction

    task automatic model_accept();
        e_valid = 1'b1;
        e_held  = 1'b1;
        e_codf  = m_row[1:0];
        e_code  = {m_row[1:0], m_col[1:0]};
        m_mode  = 2;
        m_cnt   = 0;
        m_rel   = 0;
    endtask

    always @(posedge clk) begin
        logic [3:0] fs;
        int r;
        if (!rst_n) begin
            m_div = 0; m_col = 0; m_mode = 0; m_row = 0; m_cnt = 0; m_rel = 0;
            m_s1 = 4'b1111; m_s2 = 4'b1111;
            e_codf = 2'd0; e_code = 4'd0; e_valid = 1'b0; e_held = 1'b0;
            m_ready = 1;
        end else begin
            fs = m_s2;
            e_valid = 1'b0;
            if (m_div == SD - 1) begin
                case (m_mode)
                    0: begin
                        r = low_index(fs);
                        if (r >= 0) begin
                            m_row = r;
                            m_cnt = 1;
                            if (m_cnt >= DC) model_accept(); else m_mode = 1;
                        end else m_col = (m_col + 1) % 4;
                    end
                    1: begin
                        if (fs == strobe(m_row)) begin
                            m_cnt++;
                            if (m_cnt >= DC) model_accept();
                        end else begin
                            m_cnt = 0; m_mode = 0; m_col = (m_col + 1) % 4;
                        end
                    end
                    default: begin
                        if (fs[m_row]) begin
                            m_rel++;
                            if (m_rel >= DC) begin
                                m_rel = 0; e_held = 1'b0; m_mode = 0;
                                m_col = (m_col + 1) % 4;
                            end
                        end else m_rel = 0;
                    end
                endcase
            end
            m_div = (m_div + 1) % SD;
            m_s2 = m_s1;
            m_s1 = fila;
        end
        #1;
        if (m_ready) begin
            chk("m_columna", columna, strobe(m_col));
            chk("m_codc", codc, m_col);
            chk("m_codf", codf, e_codf);
            chk("m_key_code", key_code, e_code);
            chk("m_key_valid", key_valid, e_valid);
            chk("m_key_held", key_held, e_held);
        end
        if (key_valid === 1'b1) pulse_count++;
    end

    // ---------------- driver tasks ----------------
    // Returns on the first cycle of a dwell on column pattern pat.
    task automatic wait_col(input logic [3:0] pat);
        int n = 0;
        while (columna == pat && n < 64) begin @(negedge clk); n++; end
        while (columna != pat && n < 64) begin @(negedge clk); n++; end
        chk("wait_col_timeout", (n < 64), 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (key_valid !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        chk("wait_valid_timeout", (n < 64), 1);
    endtask

    task automatic wait_release();
        int n = 0;
        while (key_held !== 1'b0 && n < 64) begin @(negedge clk); n++; end
        chk("wait_release_timeout", (n < 64), 1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_columna"}, columna, 4'b1110);
        chk({tag, "_codc"}, codc, 2'b00);
        chk({tag, "_codf"}, codf, 2'b00);
        chk({tag, "_key_code"}, key_code, 4'b0000);
        chk({tag, "_valid"}, key_valid, 1'b0);
        chk({tag, "_held"}, key_held, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] seq [4];
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;

        // Reset with all rows low: synchronizer must still come up idle.
        rst_n = 1'b0;
        fila  = 4'b0000;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");

        // Idle scan: each strobe held for 4 cycles, wrapping to 1110.
        fila  = 4'b1111;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk("scan_seq", columna, seq[(k / 4) % 4]);
            @(negedge clk);
        end

        // Clean press of row 2 on column 1.
        wait_col(4'b1101);
        pulse_count = 0;
        fila = 4'b1011;
        wait_valid();
        chk("press_key_code", key_code, 4'b1001);
        chk("press_codf", codf, 2'b10);
        chk("press_held", key_held, 1'b1);
        chk("press_columna", columna, 4'b1101);
        repeat (24) @(negedge clk);
        chk("press_single_pulse", pulse_count, 1);
        chk("press_frozen", columna, 4'b1101);

        // Release with a one-tick glitch back to the pressed row.
        fila = 4'b1111;
        repeat (6) @(negedge clk);
        fila = 4'b1011;
        repeat (4) @(negedge clk);
        fila = 4'b1111;
        chk("release_still_held", key_held, 1'b1);
        wait_release();
        chk("release_columna", columna, 4'b1011);
        chk("release_codf_kept", codf, 2'b10);
        chk("release_code_kept", key_code, 4'b1001);

        // Bounce: one tick of row 3 on column 0, then nothing.
        wait_col(4'b1110);
        pulse_count = 0;
        fila = 4'b0111;
        repeat (4) @(negedge clk);
        fila = 4'b1111;
        repeat (5) @(negedge clk);
        chk("bounce_columna", columna, 4'b1101);
        chk("bounce_no_pulse", pulse_count, 0);

        // Two rows low is not a key.
        pulse_count = 0;
        fila = 4'b1100;
        repeat (24) @(negedge clk);
        chk("multi_no_pulse", pulse_count, 0);
        fila = 4'b1111;
        repeat (4) @(negedge clk);

        // Reset while confirming a press.
        wait_col(4'b0111);
        pulse_count = 0;
        fila = 4'b1110;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_values("rst_debounce");
        rst_n = 1'b1;
        fila  = 4'b1111;
        repeat (12) @(negedge clk);
        chk("rst_debounce_no_pulse", pulse_count, 0);

        // Reset while holding a key.
        wait_col(4'b1011);
        fila = 4'b0111;
        wait_valid();
        chk("hold_key_code", key_code, 4'b1110);
        repeat (3) @(negedge clk);
        pulse_count = 0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_values("rst_hold");
        rst_n = 1'b1;
        fila  = 4'b1111;
        repeat (8) @(negedge clk);
        chk("rst_hold_no_pulse", pulse_count, 0);

        // Randomized segments checked by the model.
        for (int s = 0; s < 80; s++) begin
            int sel = $urandom_range(0, 99);
            if (sel < 35) fila = 4'b1111;
            else if (sel < 80) begin
                fila = 4'b1111;
                fila[$urandom_range(0, 3)] = 1'b0;
            end else if (sel < 90) fila = 4'b1100;
            else fila = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 4) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        fila = 4'b1111;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/module_keypad_scan.md
# module_keypad_scan

Scanning controller for the 4x4 matrix keypad. It rotates an active-low column strobe and samples the four active-low row lines through a two-flop synchronizer. It debounces a single pressed key and emits one registered key event per press. It sequences the column-select and row-encode path: it owns the column code, the row code and the strobe timing that the keypad encoder consumes.

## Interface

Parameters:
- SCAN_DIV, default 27000: clock cycles per column dwell (1 ms at 27 MHz); minimum 2.
- DEBOUNCE_CNT, default 4: consecutive matching samples required to accept a press or a release; minimum 1.

Ports:
- clk_i  input  1  system clock; the only clock.
- rst_n_i  input  1  reset, synchronous, active-low.
- fila_i  input  4  raw row lines, active-low, asynchronous to clk_i.
- columna_o  output  4  column strobe, one-hot low: code 00→1110, 01→1101, 10→1011, 11→0111.
- dato_codc_o  output  2  current column code.
- dato_codf_o  output  2  row code of the last accepted key: 1110→00, 1101→01, 1011→10, 0111→11.
- key_code_o  output  4  {dato_codf_o, dato_codc_o} latched at acceptance.
- key_valid_o  output  1  one-cycle pulse when a press is accepted.
- key_held_o  output  1  high while the accepted key remains pressed.

## Operation

- **Row synchronizer:** fila_i passes through 2 flops, which reset to 1111. All decisions use the synchronized value (fila_s).
- **Dwell divider and sample tick:** the divider counts 0..SCAN_DIV-1 and wraps to 0. A sample tick occurs on the cycle the count equals SCAN_DIV-1.
- **Valid row pattern:** exactly one bit of fila_s is low. Patterns 1111, or any pattern with two or more low bits, count as "no key".

FSM states:
- **SCAN**
  - On tick with a valid row pattern: latch the row code and the current column, set match count = 1, go to DEBOUNCE. The column does not advance.
  - On tick with no valid row pattern: advance the column code by 1 mod 4 (11→00).
- **DEBOUNCE**
  - The column is frozen.
  - On tick, if fila_s matches the latched row: increment the match count.
  - When the count reaches DEBOUNCE_CNT: pulse key_valid_o, update dato_codf_o and key_code_o, go to HOLD.
  - On tick with a mismatch: clear the count, advance the column, go to SCAN.
  - DEBOUNCE_CNT = 1: acceptance happens on the detecting tick itself (SCAN goes directly to HOLD).
- **HOLD**
  - The column is frozen and key_held_o = 1.
  - On tick, if the latched row is not low: increment the release count.
  - On tick, if the latched row is low again: clear the release count.
  - When the release count reaches DEBOUNCE_CNT: clear key_held_o, advance the column, go to SCAN.
  - Extra rows going low while in HOLD are ignored (no rollover support).

Register and width rules:
- dato_codf_o and key_code_o hold their value until the next acceptance.
- dato_codc_o always tracks the live column.
- Counters are wide enough for their parameter values and saturate at their limit; they never wrap.

## Timing

Reset values (applied on the first rising edge with rst_n_i = 0):
- columna_o = 1110, dato_codc_o = 00.
- dato_codf_o = 00, key_code_o = 0000.
- key_valid_o = 0, key_held_o = 0.
- State SCAN; divider and counters = 0; synchronizer flops = 1111.

Cycle-level behaviour:
- All outputs are registered. columna_o and dato_codc_o change on the cycle after a tick.
- Row latency: a row change at fila_i is visible in fila_s 2 cycles later.
- Press latency: the press must be stable before the detecting tick. key_valid_o and key_held_o rise 1 cycle after the tick where the count reaches DEBOUNCE_CNT, which is (DEBOUNCE_CNT-1)*SCAN_DIV + 1 cycles after the detecting tick. Worst case from press to detecting tick is 4*SCAN_DIV + 2 cycles.
- key_valid_o is high for exactly 1 cycle per accepted press. A key held indefinitely produces no repeat pulses.
- Release latency: key_held_o falls 1 cycle after the DEBOUNCE_CNT-th consecutive released tick.
- rst_n_i low in any state overrides everything. No key_valid_o pulse is emitted on the edge where reset is sampled.

## Test plan

Bench parameters: SCAN_DIV = 4, DEBOUNCE_CNT = 3.

- **Reset:** hold rst_n_i = 0 for 3 cycles with fila_i = 0000 → columna_o = 1110, dato_codc_o = 00, dato_codf_o = 00, key_code_o = 0000, key_valid_o = 0, key_held_o = 0. Release reset with fila_i = 1111 → columna_o = 1110, 1101, 1011, 0111, 1110, each held 4 cycles.
- **Clean press:** drive fila_i = 1011 only while columna_o = 1101, and keep it asserted → exactly one key_valid_o pulse, key_code_o = 1001, dato_codf_o = 10, key_held_o = 1, columna_o frozen at 1101.
- **Bounce:** fila_i = 0111 for 1 tick at column 00, then 1111 → no key_valid_o pulse, FSM back to SCAN, columna_o advances to 1101.
- **Release:** from the clean-press HOLD, set fila_i = 1111 → key_held_o falls after 3 ticks and columna_o advances to 1011. A 1-tick glitch back to 1011 during release restarts the release count.
- **Multiple rows:** fila_i = 1100 at any column → treated as no key; scanning continues with no key_valid_o pulse.
- **Reset mid-operation:** assert rst_n_i during DEBOUNCE, and separately during HOLD → all outputs take their reset values on that edge, no key_valid_o pulse, and scanning restarts at 1110.
